// File: rtl/rf_port_arbiter_pkg.sv
// ----------------------------------------------------------------------------
// rf_port_arbiter_pkg
//   Shared constants and types for the register-file port arbiter.
//   - DATA_INDEX_LIMIT / REG_ADDR_INDEX_LIMIT: MSB index of a register word
//     and of a register address (32x32 register file).
//   - rfa_state_e: arbiter ownership state (2-bit encoding).
//   - rfa_req_id_e: requester identity, used for the round-robin history.
// ----------------------------------------------------------------------------
package rf_port_arbiter_pkg;

  localparam int DATA_INDEX_LIMIT     = 31;
  localparam int REG_ADDR_INDEX_LIMIT = 4;
  localparam int RF_DATA_WIDTH        = DATA_INDEX_LIMIT + 1;
  localparam int RF_ADDR_WIDTH        = REG_ADDR_INDEX_LIMIT + 1;
  localparam int RF_MAX_LOCK          = 8;

  typedef enum logic [1:0] {
    RFA_IDLE = 2'b00,
    RFA_OWN0 = 2'b01,
    RFA_OWN1 = 2'b10
  } rfa_state_e;

  typedef enum logic {
    REQ_WB  = 1'b0,   // requester 0: writeback unit
    REQ_SEQ = 1'b1    // requester 1: control/debug sequencer
  } rfa_req_id_e;

  // Ownership state entered when requester `id` takes a lock.
  function automatic rfa_state_e own_state(input rfa_req_id_e id);
    return (id == REQ_SEQ) ? RFA_OWN1 : RFA_OWN0;
  endfunction

endpackage

// File: rtl/rf_port_arbiter_rr_arbiter_2.sv
// ----------------------------------------------------------------------------
// rr_arbiter_2
//   Combinational two-way round-robin pick.
//   Ports:
//     req        in  [1:0]  request vector, bit i = requester i
//     last_grant in         requester granted most recently
//     gnt        out [1:0]  one-hot (or zero) grant vector
//   A lone requester always wins; on a tie the requester that was not
//   granted last wins.
// ----------------------------------------------------------------------------
module rr_arbiter_2
  import rf_port_arbiter_pkg::*;
(
  input  logic [1:0]  req,
  input  rfa_req_id_e last_grant,
  output logic [1:0]  gnt
);

  always_comb begin
    // NOTE: every combinational output gets a default first so no path
    // through the case can leave it unassigned and infer a latch.
    gnt = 2'b00;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = (last_grant == REQ_WB) ? 2'b10 : 2'b01;
      default: gnt = 2'b00;
    endcase
  end

endmodule

// File: rtl/rf_port_arbiter.sv
// ----------------------------------------------------------------------------
// rf_port_arbiter
//   Shares the single access port of a 32x32 register file (one write or one
//   dual read per cycle) between requester 0 (writeback) and requester 1
//   (control/debug sequencer). Round-robin arbitration with an optional
//   bounded lock (at most MAX_LOCK consecutive granted cycles).
//
//   Ports:
//     CLK, RST                 clock; synchronous active-low reset
//     REQ*, LOCK*, WE*         request, keep-ownership, write(1)/read(0)
//     ADDR_W*, DATA_W*         write address / data per requester
//     ADDR_R1_*, ADDR_R2_*     dual read addresses per requester
//     GNT*                     combinational grant, access happens this cycle
//     RVALID*, RDATA1_*/2_*    registered read response (1-cycle latency)
//     RF_READ, RF_WRITE        register file strobes
//     RF_ADDR_W/R1/R2          register file addresses
//     RF_DATA_W                register file write data
//     RF_DATA_R1, RF_DATA_R2   register file read data (sampled on reads)
// ----------------------------------------------------------------------------
module rf_port_arbiter
  import rf_port_arbiter_pkg::*;
#(
  parameter int DATA_WIDTH = RF_DATA_WIDTH,
  parameter int ADDR_WIDTH = RF_ADDR_WIDTH,
  parameter int MAX_LOCK   = RF_MAX_LOCK     // must be >= 2
) (
  input  logic                  CLK,
  input  logic                  RST,

  input  logic                  REQ0,
  input  logic                  REQ1,
  input  logic                  LOCK0,
  input  logic                  LOCK1,
  input  logic                  WE0,
  input  logic                  WE1,
  input  logic [ADDR_WIDTH-1:0] ADDR_W0,
  input  logic [ADDR_WIDTH-1:0] ADDR_W1,
  input  logic [DATA_WIDTH-1:0] DATA_W0,
  input  logic [DATA_WIDTH-1:0] DATA_W1,
  input  logic [ADDR_WIDTH-1:0] ADDR_R1_0,
  input  logic [ADDR_WIDTH-1:0] ADDR_R2_0,
  input  logic [ADDR_WIDTH-1:0] ADDR_R1_1,
  input  logic [ADDR_WIDTH-1:0] ADDR_R2_1,

  output logic                  GNT0,
  output logic                  GNT1,
  output logic                  RVALID0,
  output logic                  RVALID1,
  output logic [DATA_WIDTH-1:0] RDATA1_0,
  output logic [DATA_WIDTH-1:0] RDATA2_0,
  output logic [DATA_WIDTH-1:0] RDATA1_1,
  output logic [DATA_WIDTH-1:0] RDATA2_1,

  output logic                  RF_READ,
  output logic                  RF_WRITE,
  output logic [ADDR_WIDTH-1:0] RF_ADDR_W,
  output logic [ADDR_WIDTH-1:0] RF_ADDR_R1,
  output logic [ADDR_WIDTH-1:0] RF_ADDR_R2,
  output logic [DATA_WIDTH-1:0] RF_DATA_W,
  input  logic [DATA_WIDTH-1:0] RF_DATA_R1,
  input  logic [DATA_WIDTH-1:0] RF_DATA_R2
);

  // Counter holds 0..MAX_LOCK-1 granted cycles already spent in a lock.
  localparam int                CNT_W     = (MAX_LOCK > 2) ? $clog2(MAX_LOCK) : 1;
  localparam logic [CNT_W-1:0]  LOCK_LAST = CNT_W'(MAX_LOCK - 1);

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  rfa_state_e             state_q,      state_d;
  rfa_req_id_e            last_grant_q, last_grant_d;
  logic [CNT_W-1:0]       lock_cnt_q,   lock_cnt_d;
  logic                   rvalid0_q,    rvalid0_d;
  logic                   rvalid1_q,    rvalid1_d;
  logic [DATA_WIDTH-1:0]  rdata1_0_q,   rdata1_0_d;
  logic [DATA_WIDTH-1:0]  rdata2_0_q,   rdata2_0_d;
  logic [DATA_WIDTH-1:0]  rdata1_1_q,   rdata1_1_d;
  logic [DATA_WIDTH-1:0]  rdata2_1_q,   rdata2_1_d;

  // --------------------------------------------------------------------------
  // Round-robin pick, only consulted in IDLE
  // --------------------------------------------------------------------------
  logic [1:0] rr_gnt;

  rr_arbiter_2 u_rr_arbiter_2 (
    .req        ({REQ1, REQ0}),
    .last_grant (last_grant_q),
    .gnt        (rr_gnt)
  );

  // --------------------------------------------------------------------------
  // Grant and next-state logic
  // --------------------------------------------------------------------------
  logic        gnt0, gnt1;
  logic        any_gnt;
  logic        gnt_lock;
  rfa_req_id_e gnt_id;

  always_comb begin
    gnt0         = 1'b0;
    gnt1         = 1'b0;
    state_d      = state_q;
    lock_cnt_d   = lock_cnt_q;
    last_grant_d = last_grant_q;

    // No access may be issued while reset is asserted.
    if (RST) begin
      case (state_q)
        RFA_IDLE: {gnt1, gnt0} = rr_gnt;
        RFA_OWN0: gnt0 = REQ0;
        RFA_OWN1: gnt1 = REQ1;
        default:  ;
      endcase
    end

    any_gnt  = gnt0 | gnt1;
    gnt_id   = gnt1 ? REQ_SEQ : REQ_WB;
    gnt_lock = gnt1 ? LOCK1 : LOCK0;

    if (any_gnt) begin
      last_grant_d = gnt_id;
      if (state_q == RFA_IDLE) begin
        if (gnt_lock) begin
          state_d    = own_state(gnt_id);
          lock_cnt_d = CNT_W'(1);
        end
      end else if (gnt_lock && (lock_cnt_q < LOCK_LAST)) begin
        lock_cnt_d = lock_cnt_q + CNT_W'(1);
      end else begin
        // Lock dropped, or the MAX_LOCK-th granted cycle: forced release.
        state_d    = RFA_IDLE;
        lock_cnt_d = '0;
      end
    end else if (state_q != RFA_IDLE) begin
      // Owner withdrew its request (or an unused encoding): release.
      state_d    = RFA_IDLE;
      lock_cnt_d = '0;
    end
  end

  // --------------------------------------------------------------------------
  // Register file port mux; all pins are zero when nobody is granted
  // --------------------------------------------------------------------------
  always_comb begin
    RF_READ    = 1'b0;
    RF_WRITE   = 1'b0;
    RF_ADDR_W  = '0;
    RF_ADDR_R1 = '0;
    RF_ADDR_R2 = '0;
    RF_DATA_W  = '0;

    if (gnt0) begin
      if (WE0) begin
        RF_WRITE  = 1'b1;
        RF_ADDR_W = ADDR_W0;
        RF_DATA_W = DATA_W0;
      end else begin
        RF_READ    = 1'b1;
        RF_ADDR_R1 = ADDR_R1_0;
        RF_ADDR_R2 = ADDR_R2_0;
      end
    end else if (gnt1) begin
      if (WE1) begin
        RF_WRITE  = 1'b1;
        RF_ADDR_W = ADDR_W1;
        RF_DATA_W = DATA_W1;
      end else begin
        RF_READ    = 1'b1;
        RF_ADDR_R1 = ADDR_R1_1;
        RF_ADDR_R2 = ADDR_R2_1;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Read response capture: data sampled at the edge ending the read cycle
  // --------------------------------------------------------------------------
  always_comb begin
    rvalid0_d  = gnt0 & ~WE0;
    rvalid1_d  = gnt1 & ~WE1;
    rdata1_0_d = rvalid0_d ? RF_DATA_R1 : rdata1_0_q;
    rdata2_0_d = rvalid0_d ? RF_DATA_R2 : rdata2_0_q;
    rdata1_1_d = rvalid1_d ? RF_DATA_R1 : rdata1_1_q;
    rdata2_1_d = rvalid1_d ? RF_DATA_R2 : rdata2_1_q;
  end

  // --------------------------------------------------------------------------
  // Sequential state
  // --------------------------------------------------------------------------
  // NOTE: state uses non-blocking assignments so every flop samples the
  // pre-edge value of every other flop, independent of statement order.
  // NOTE: reset is synchronous (RST only sampled at the rising edge) and
  // aborts any lock and any pending response.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_q      <= RFA_IDLE;
      last_grant_q <= REQ_SEQ;   // requester 0 wins the first tie
      lock_cnt_q   <= '0;
      rvalid0_q    <= 1'b0;
      rvalid1_q    <= 1'b0;
      rdata1_0_q   <= '0;
      rdata2_0_q   <= '0;
      rdata1_1_q   <= '0;
      rdata2_1_q   <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      lock_cnt_q   <= lock_cnt_d;
      rvalid0_q    <= rvalid0_d;
      rvalid1_q    <= rvalid1_d;
      rdata1_0_q   <= rdata1_0_d;
      rdata2_0_q   <= rdata2_0_d;
      rdata1_1_q   <= rdata1_1_d;
      rdata2_1_q   <= rdata2_1_d;
    end
  end

  assign GNT0     = gnt0;
  assign GNT1     = gnt1;
  assign RVALID0  = rvalid0_q;
  assign RVALID1  = rvalid1_q;
  assign RDATA1_0 = rdata1_0_q;
  assign RDATA2_0 = rdata2_0_q;
  assign RDATA1_1 = rdata1_1_q;
  assign RDATA2_1 = rdata2_1_q;

endmodule

// File: tb/tb_rf_port_arbiter.sv
// ----------------------------------------------------------------------------
// tb_rf_port_arbiter
//   Directed bench for rf_port_arbiter with a behavioural 32x32 register
//   file. Each stimulus cycle pushes its expected port activity into a
//   queue; expected read responses go into per-requester queues. A monitor
//   on the falling edge pops and compares.
// ----------------------------------------------------------------------------
module tb_rf_port_arbiter;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int ML = 8;

  logic          CLK = 1'b0;
  logic          RST;
  logic          REQ0, REQ1, LOCK0, LOCK1, WE0, WE1;
  logic [AW-1:0] ADDR_W0, ADDR_W1, ADDR_R1_0, ADDR_R2_0, ADDR_R1_1, ADDR_R2_1;
  logic [DW-1:0] DATA_W0, DATA_W1;
  logic          GNT0, GNT1, RVALID0, RVALID1;
  logic [DW-1:0] RDATA1_0, RDATA2_0, RDATA1_1, RDATA2_1;
  logic          RF_READ, RF_WRITE;
  logic [AW-1:0] RF_ADDR_W, RF_ADDR_R1, RF_ADDR_R2;
  logic [DW-1:0] RF_DATA_W, RF_DATA_R1, RF_DATA_R2;

  always #5 CLK = ~CLK;

  rf_port_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MAX_LOCK(ML)) dut (
    .CLK(CLK), .RST(RST),
    .REQ0(REQ0), .REQ1(REQ1), .LOCK0(LOCK0), .LOCK1(LOCK1),
    .WE0(WE0), .WE1(WE1),
    .ADDR_W0(ADDR_W0), .ADDR_W1(ADDR_W1), .DATA_W0(DATA_W0), .DATA_W1(DATA_W1),
    .ADDR_R1_0(ADDR_R1_0), .ADDR_R2_0(ADDR_R2_0),
    .ADDR_R1_1(ADDR_R1_1), .ADDR_R2_1(ADDR_R2_1),
    .GNT0(GNT0), .GNT1(GNT1), .RVALID0(RVALID0), .RVALID1(RVALID1),
    .RDATA1_0(RDATA1_0), .RDATA2_0(RDATA2_0), .RDATA1_1(RDATA1_1), .RDATA2_1(RDATA2_1),
    .RF_READ(RF_READ), .RF_WRITE(RF_WRITE),
    .RF_ADDR_W(RF_ADDR_W), .RF_ADDR_R1(RF_ADDR_R1), .RF_ADDR_R2(RF_ADDR_R2),
    .RF_DATA_W(RF_DATA_W), .RF_DATA_R1(RF_DATA_R1), .RF_DATA_R2(RF_DATA_R2)
  );

  // Behavioural register file: initial word i = 0xA000_0000 | i.
  logic [DW-1:0] rf_mem [32];
  bit            rf_init_done = 1'b0;

  always @(posedge CLK) begin
    if (!rf_init_done) begin
      for (int i = 0; i < 32; i++) rf_mem[i] <= 32'hA000_0000 | i;
      rf_init_done <= 1'b1;
    end else if (RF_WRITE) begin
      rf_mem[RF_ADDR_W] <= RF_DATA_W;
    end
  end

  assign RF_DATA_R1 = RF_READ ? rf_mem[RF_ADDR_R1] : '0;
  assign RF_DATA_R2 = RF_READ ? rf_mem[RF_ADDR_R2] : '0;

  // --------------------------------------------------------------------------
  // Scoreboard types and state
  // --------------------------------------------------------------------------
  typedef struct packed {
    logic          rst, r0, r1, l0, l1, w0, w1;
    logic [AW-1:0] aw0, aw1, a10, a20, a11, a21;
    logic [DW-1:0] dw0, dw1;
  } stim_t;

  typedef struct {
    string         tag;
    logic          g0, g1, rd, wr, rv0, rv1;
    logic [AW-1:0] aw, ar1, ar2;
    logic [DW-1:0] dw;
    bit            rzero;
  } exp_t;

  typedef struct {
    string         tag;
    logic [DW-1:0] d1, d2;
  } rsp_t;

  exp_t  cyc_q[$];
  rsp_t  rsp0_q[$];
  rsp_t  rsp1_q[$];
  stim_t s;
  logic [DW-1:0] exp_mem [32];
  logic  exp_rv0_nxt = 1'b0;
  logic  exp_rv1_nxt = 1'b0;
  int    checks = 0;
  int    errors = 0;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Apply the pending stimulus for one clock cycle and record what the DUT
  // must show during that cycle. eg0/eg1 are the hand-derived grants.
  task automatic cyc(input string tag, input bit eg0, input bit eg1, input bit rzero = 1'b0);
    exp_t e;
    rsp_t r;
    @(posedge CLK);
    #1;
    RST = s.rst;  REQ0 = s.r0;  REQ1 = s.r1;  LOCK0 = s.l0;  LOCK1 = s.l1;
    WE0 = s.w0;   WE1 = s.w1;
    ADDR_W0 = s.aw0;  ADDR_W1 = s.aw1;  DATA_W0 = s.dw0;  DATA_W1 = s.dw1;
    ADDR_R1_0 = s.a10;  ADDR_R2_0 = s.a20;  ADDR_R1_1 = s.a11;  ADDR_R2_1 = s.a21;

    e.tag = tag;  e.g0 = eg0;  e.g1 = eg1;  e.rzero = rzero;
    e.rd = 1'b0;  e.wr = 1'b0;  e.aw = '0;  e.ar1 = '0;  e.ar2 = '0;  e.dw = '0;
    e.rv0 = exp_rv0_nxt;  e.rv1 = exp_rv1_nxt;
    r.tag = tag;
    if (eg0 && s.w0) begin
      e.wr = 1'b1;  e.aw = s.aw0;  e.dw = s.dw0;  exp_mem[s.aw0] = s.dw0;
    end else if (eg0) begin
      e.rd = 1'b1;  e.ar1 = s.a10;  e.ar2 = s.a20;
      r.d1 = exp_mem[s.a10];  r.d2 = exp_mem[s.a20];  rsp0_q.push_back(r);
    end else if (eg1 && s.w1) begin
      e.wr = 1'b1;  e.aw = s.aw1;  e.dw = s.dw1;  exp_mem[s.aw1] = s.dw1;
    end else if (eg1) begin
      e.rd = 1'b1;  e.ar1 = s.a11;  e.ar2 = s.a21;
      r.d1 = exp_mem[s.a11];  r.d2 = exp_mem[s.a21];  rsp1_q.push_back(r);
    end
    exp_rv0_nxt = s.rst & eg0 & ~s.w0;
    exp_rv1_nxt = s.rst & eg1 & ~s.w1;
    cyc_q.push_back(e);
  endtask

  // --------------------------------------------------------------------------
  // Monitor: mid-cycle sampling
  // --------------------------------------------------------------------------
  exp_t mon_e;
  rsp_t mon_r;

  always @(negedge CLK) begin
    if (cyc_q.size() > 0) begin
      mon_e = cyc_q.pop_front();
      check({mon_e.tag, ".gnt0"},     32'(GNT0),       32'(mon_e.g0));
      check({mon_e.tag, ".gnt1"},     32'(GNT1),       32'(mon_e.g1));
      check({mon_e.tag, ".rf_read"},  32'(RF_READ),    32'(mon_e.rd));
      check({mon_e.tag, ".rf_write"}, 32'(RF_WRITE),   32'(mon_e.wr));
      check({mon_e.tag, ".rvalid0"},  32'(RVALID0),    32'(mon_e.rv0));
      check({mon_e.tag, ".rvalid1"},  32'(RVALID1),    32'(mon_e.rv1));
      check({mon_e.tag, ".addr_w"},   32'(RF_ADDR_W),  32'(mon_e.aw));
      check({mon_e.tag, ".addr_r1"},  32'(RF_ADDR_R1), 32'(mon_e.ar1));
      check({mon_e.tag, ".addr_r2"},  32'(RF_ADDR_R2), 32'(mon_e.ar2));
      check({mon_e.tag, ".data_w"},   RF_DATA_W,       mon_e.dw);
      if (mon_e.rzero) begin
        check({mon_e.tag, ".rdata1_0"}, RDATA1_0, '0);
        check({mon_e.tag, ".rdata2_0"}, RDATA2_0, '0);
        check({mon_e.tag, ".rdata1_1"}, RDATA1_1, '0);
        check({mon_e.tag, ".rdata2_1"}, RDATA2_1, '0);
      end
    end
    if (RVALID0 === 1'b1) begin
      if (rsp0_q.size() == 0) begin
        checks++;  errors++;
        $display("FAIL rsp0_unexpected: got RVALID0=1 expected no response");
      end else begin
        mon_r = rsp0_q.pop_front();
        check({mon_r.tag, ".rdata1_0"}, RDATA1_0, mon_r.d1);
        check({mon_r.tag, ".rdata2_0"}, RDATA2_0, mon_r.d2);
      end
    end
    if (RVALID1 === 1'b1) begin
      if (rsp1_q.size() == 0) begin
        checks++;  errors++;
        $display("FAIL rsp1_unexpected: got RVALID1=1 expected no response");
      end else begin
        mon_r = rsp1_q.pop_front();
        check({mon_r.tag, ".rdata1_1"}, RDATA1_1, mon_r.d1);
        check({mon_r.tag, ".rdata2_1"}, RDATA2_1, mon_r.d2);
      end
    end
  end

  // --------------------------------------------------------------------------
  // Stimulus
  // --------------------------------------------------------------------------
  initial begin
    for (int i = 0; i < 32; i++) exp_mem[i] = 32'hA000_0000 | i;
    s = '0;
    RST = 1'b0;  REQ0 = 1'b0;  REQ1 = 1'b0;  LOCK0 = 1'b0;  LOCK1 = 1'b0;
    WE0 = 1'b0;  WE1 = 1'b0;
    ADDR_W0 = '0;  ADDR_W1 = '0;  DATA_W0 = '0;  DATA_W1 = '0;
    ADDR_R1_0 = '0;  ADDR_R2_0 = '0;  ADDR_R1_1 = '0;  ADDR_R2_1 = '0;
    repeat (2) @(posedge CLK);

    // Reset held: nothing granted, responses cleared.
    s.r0 = 1'b1;  s.r1 = 1'b1;
    cyc("rst_hold", 1'b0, 1'b0, 1'b1);

    // Both read, no lock: 0,1,0,1 (requester 0 wins the first tie).
    s.rst = 1'b1;
    s.a10 = 5'd1;  s.a20 = 5'd2;  s.a11 = 5'd3;  s.a21 = 5'd4;
    cyc("rr_a", 1'b1, 1'b0);
    cyc("rr_b", 1'b0, 1'b1);
    cyc("rr_c", 1'b1, 1'b0);
    cyc("rr_d", 1'b0, 1'b1);

    // Write 0xDEADBEEF to R5 by req0, then req1 reads R5 twice.
    s.r1 = 1'b0;  s.w0 = 1'b1;  s.aw0 = 5'd5;  s.dw0 = 32'hDEAD_BEEF;
    cyc("wr_r5", 1'b1, 1'b0);
    s.r0 = 1'b0;  s.w0 = 1'b0;  s.r1 = 1'b1;  s.a11 = 5'd5;  s.a21 = 5'd5;
    cyc("rd_r5", 1'b0, 1'b1);

    // Req1 locks while req0 keeps requesting: req0 first (last was 1),
    // then exactly ML grants to req1, then req0 again.
    s.r0 = 1'b1;  s.a10 = 5'd6;  s.a20 = 5'd7;  s.l1 = 1'b1;
    cyc("lock1_pre", 1'b1, 1'b0);
    for (int i = 0; i < ML; i++) begin
      s.a11 = 5'(i);  s.a21 = 5'(31 - i);
      cyc($sformatf("lock1_%0d", i), 1'b0, 1'b1);
    end
    cyc("lock1_release", 1'b1, 1'b0);

    // Req0 locked writes for 2 cycles, then drops REQ0: idle cycle, then
    // waiting req1 reads the freshly written words.
    s.r1 = 1'b0;  s.l1 = 1'b0;
    s.l0 = 1'b1;  s.w0 = 1'b1;  s.aw0 = 5'd10;  s.dw0 = 32'h1234_5678;
    cyc("lock0_w10", 1'b1, 1'b0);
    s.r1 = 1'b1;  s.a11 = 5'd10;  s.a21 = 5'd11;
    s.aw0 = 5'd11;  s.dw0 = 32'hCAFE_F00D;
    cyc("lock0_w11", 1'b1, 1'b0);
    s.r0 = 1'b0;
    cyc("lock0_drop", 1'b0, 1'b0);
    cyc("lock0_wait1", 1'b0, 1'b1);

    // Reset during a read grant of a locked owner: grant suppressed,
    // pending response cleared, ownership aborted.
    s.r1 = 1'b0;  s.r0 = 1'b1;  s.l0 = 1'b1;  s.w0 = 1'b0;
    s.a10 = 5'd5;  s.a20 = 5'd10;
    cyc("rst_prelock", 1'b1, 1'b0);
    s.rst = 1'b0;
    cyc("rst_mid", 1'b0, 1'b0);
    s.rst = 1'b1;  s.r0 = 1'b0;  s.l0 = 1'b0;
    s.r1 = 1'b1;  s.a11 = 5'd11;  s.a21 = 5'd5;
    cyc("rst_after", 1'b0, 1'b1, 1'b1);

    // Idle: all port outputs zero.
    s.r1 = 1'b0;
    cyc("idle_0", 1'b0, 1'b0);
    cyc("idle_1", 1'b0, 1'b0);
    cyc("idle_2", 1'b0, 1'b0);

    @(negedge CLK);
    #1;
    check("cyc_q_drained", 32'(cyc_q.size()), 32'd0);
    check("rsp0_q_drained", 32'(rsp0_q.size()), 32'd0);
    check("rsp1_q_drained", 32'(rsp1_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
